// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment scan driver.
//   seg_t        : 7-bit active-low segment pattern, bit0 = a ... bit6 = g
//   SEG_BLANK    : all segments off
//   SEG_HEX_LUT  : hex nibble -> active-low segment pattern
//   seg_encode() : table lookup helper
//   scan_state_e : scan progress (first slot after reset vs running)
// ---------------------------------------------------------------------------
package seg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t SEG_BLANK = 7'h7F;

   // Index is the nibble value; entries are the active-low pattern for 0..F.
   localparam seg_t SEG_HEX_LUT [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Scan progress: busy stays low only until the first slot wrap.
   typedef enum logic {
      SCAN_FIRST = 1'b0,
      SCAN_RUN   = 1'b1
   } scan_state_e;

   function automatic seg_t seg_encode(input logic [3:0] nib);
      return SEG_HEX_LUT[nib];
   endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// ---------------------------------------------------------------------------
// seg_lz_mask
// Purely combinational leading-zero detector. A digit is flagged for blanking
// when it and every more-significant digit are zero. Digit 0 is never flagged
// so an all-zero word still shows a single "0".
//   shadow_i : 4*DIGITS-bit hex word, digit 0 in bits [3:0]
//   blank_o  : DIGITS-bit mask, 1 = digit is a leading zero
// ---------------------------------------------------------------------------
module seg_lz_mask #(
   parameter int DIGITS = 8
) (
   input  logic [4*DIGITS-1:0] shadow_i,
   output logic [DIGITS-1:0]   blank_o
);

   logic allZero;

   // Walk from the most significant digit downwards, keeping a running
   // "everything above and including me is zero" flag.
   always_comb begin
      allZero = 1'b1;
      blank_o = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         allZero    = allZero & (shadow_i[4*i +: 4] == 4'h0);
         blank_o[i] = allZero & (i != 0);
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// ---------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed driver for a common-anode bank of DIGITS seven-segment
// displays. A hex word is captured on a load strobe and scanned one digit per
// SCAN_DIV clocks, with the first DEAD clocks of every slot fully dark to
// prevent ghosting. Optional leading-zero blanking.
//   clk        : system clock
//   reset      : asynchronous, active-high reset
//   value      : hex word, digit i = value[4i+3:4i]
//   load       : single-cycle strobe, captures value
//   lz_blank   : 1 = blank leading zero digits (sampled live)
//   blink_mask : (SEG_SCAN_BLINK_EN only) digits to blink
//   anodes     : active-low one-hot digit enable (registered)
//   segments   : active-low segment pattern (registered)
//   busy       : high once the first slot has completed
// Build option: define SEG_SCAN_BLINK_EN to add blink_mask and a free-running
// 24-bit blink counter; masked digits go blank while counter bit 23 is high.
// ---------------------------------------------------------------------------
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIGITS   = 8,
   parameter int SCAN_DIV = 1000,
   parameter int DEAD     = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [4*DIGITS-1:0] value,
   input  logic                load,
   input  logic                lz_blank,
`ifdef SEG_SCAN_BLINK_EN
   input  logic [DIGITS-1:0]   blink_mask,
`endif
   output logic [DIGITS-1:0]   anodes,
   output logic [6:0]          segments,
   output logic                busy
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [4*DIGITS-1:0] shadow_q, shadow_d;
   logic [4*DIGITS-1:0] disp_q, disp_d;
   logic [CW-1:0]       slotCnt_q, slotCnt_d;
   logic [IW-1:0]       digitIdx_q, digitIdx_d;
   scan_state_e         state_q, state_d;
   logic [DIGITS-1:0]   anodes_q, anodes_d;
   seg_t                segments_q, segments_d;

   logic                slotWrap;
   logic [DIGITS-1:0]   lzMask;
   logic [3:0]          curNib;
   logic                blinkBlank;
   logic                digitBlank;

   assign slotWrap = (slotCnt_q == CW'(SCAN_DIV - 1));

   // Leading zeros are judged on the word currently being displayed, so a
   // load in the middle of a slot cannot change the lit digit.
   seg_lz_mask #(
      .DIGITS (DIGITS)
   ) u_lz_mask (
      .shadow_i (disp_q),
      .blank_o  (lzMask)
   );

`ifdef SEG_SCAN_BLINK_EN
   logic [23:0] blinkCnt_q;

   // Free-running blink timebase; only reset clears it, load does not.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blinkCnt_q <= '0;
      end else begin
         blinkCnt_q <= blinkCnt_q + 24'd1;
      end
   end

   assign blinkBlank = blinkCnt_q[23] & blink_mask[digitIdx_q];
`else
   assign blinkBlank = 1'b0;
`endif

   // State register: everything that sequences the scan plus the pin
   // registers, all cleared to a dark display on reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shadow_q   <= '0;
         disp_q     <= '0;
         slotCnt_q  <= '0;
         digitIdx_q <= '0;
         state_q    <= SCAN_FIRST;
         anodes_q   <= '1;
         segments_q <= SEG_BLANK;
      end else begin
         shadow_q   <= shadow_d;
         disp_q     <= disp_d;
         slotCnt_q  <= slotCnt_d;
         digitIdx_q <= digitIdx_d;
         state_q    <= state_d;
         anodes_q   <= anodes_d;
         segments_q <= segments_d;
      end
   end

   // Next-state logic. The display copy only refreshes from the shadow on a
   // slot wrap, and it takes the pre-load shadow, so a load coinciding with a
   // wrap shows up one slot later. Pin values are derived from the current
   // counter/index, which gives the one-clock latency to the outputs.
   always_comb begin
      shadow_d   = shadow_q;
      disp_d     = disp_q;
      slotCnt_d  = slotCnt_q + CW'(1);
      digitIdx_d = digitIdx_q;
      state_d    = state_q;
      anodes_d   = '1;
      segments_d = SEG_BLANK;
      curNib     = 4'(disp_q >> {digitIdx_q, 2'b00});
      digitBlank = (lz_blank & lzMask[digitIdx_q]) | blinkBlank;

      if (load) begin
         shadow_d = value;
      end

      if (slotWrap) begin
         slotCnt_d = '0;
         disp_d    = shadow_q;
         if (digitIdx_q == IW'(DIGITS - 1)) begin
            digitIdx_d = '0;
         end else begin
            digitIdx_d = digitIdx_q + IW'(1);
         end
      end

      case (state_q)
         SCAN_FIRST: if (slotWrap) state_d = SCAN_RUN;
         SCAN_RUN:   state_d = SCAN_RUN;
         default:    state_d = SCAN_FIRST;
      endcase

      if (slotCnt_q >= CW'(DEAD)) begin
         anodes_d   = ~(DIGITS'(1) << digitIdx_q);
         segments_d = digitBlank ? SEG_BLANK : seg_encode(curNib);
      end
   end

   assign anodes   = anodes_q;
   assign segments = segments_q;
   assign busy     = (state_q == SCAN_RUN);

endmodule

// File: tb/tb_seg_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_driver
// Self-checking bench for seg_scan_driver with DIGITS=4, SCAN_DIV=8, DEAD=2.
// A behavioural model derives the expected pins from the number of clock
// edges since reset, the word latched at each slot start and the live
// lz_blank input.
// ---------------------------------------------------------------------------
module tb_seg_scan_driver;

   localparam int D  = 4;
   localparam int SD = 8;
   localparam int DD = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   value;
   logic          load;
   logic          lzBlank;
   logic [3:0]    anodes;
   logic [6:0]    segments;
   logic          busy;
`ifdef SEG_SCAN_BLINK_EN
   logic [3:0]    blinkMask = 4'b0000;
`endif

   int compared   = 0;
   int mismatched = 0;

   logic [6:0] hexLut [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   // Model state: edges since reset release, loaded word, word of the
   // current slot, and the expected pin values after the latest edge.
   int         mEdges;
   logic [15:0] mShadow;
   logic [15:0] mSlotWord;
   logic [3:0]  expAn;
   logic [6:0]  expSeg;
   logic        expBusy;

   seg_scan_driver #(
      .DIGITS   (D),
      .SCAN_DIV (SD),
      .DEAD     (DD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .value      (value),
      .load       (load),
      .lz_blank   (lzBlank),
`ifdef SEG_SCAN_BLINK_EN
      .blink_mask (blinkMask),
`endif
      .anodes     (anodes),
      .segments   (segments),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // One comparison: counts it, and reports it when observed != expected.
   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, mEdges);
      end
   endtask

   task automatic checkPins(input string tag);
      checkOutput({tag, ".anodes"},   {12'h000, anodes},  {12'h000, expAn});
      checkOutput({tag, ".segments"}, {9'h000, segments}, {9'h000, expSeg});
      checkOutput({tag, ".busy"},     {15'h0000, busy},   {15'h0000, expBusy});
   endtask

   // What the pins should show for a given slot position, digit and word.
   task automatic modelPins(input int cnt, input int idx, input logic [15:0] word, input logic lz);
      logic [15:0] upper;
      upper = word >> (4 * idx);
      if (cnt < DD) begin
         expAn  = 4'hF;
         expSeg = 7'h7F;
      end else begin
         expAn  = 4'hF & ~(4'b0001 << idx);
         if (lz && idx != 0 && upper == 16'h0000) expSeg = 7'h7F;
         else                                     expSeg = hexLut[upper[3:0]];
      end
   endtask

   task automatic modelReset();
      mEdges    = 0;
      mShadow   = 16'h0000;
      mSlotWord = 16'h0000;
      expAn     = 4'hF;
      expSeg    = 7'h7F;
      expBusy   = 1'b0;
   endtask

   // Drive inputs (at the falling edge), advance one clock, update the model
   // and check the pins at the next falling edge.
   task automatic applyStimulus(input logic ld, input logic [15:0] v, input logic lz, input string tag);
      int n;
      load    = ld;
      value   = v;
      lzBlank = lz;
      @(posedge clk);
      n = mEdges + 1;
      modelPins((n - 1) % SD, ((n - 1) / SD) % D, mSlotWord, lz);
      expBusy = (n >= SD);
      if (n % SD == 0) mSlotWord = mShadow;
      if (ld) mShadow = v;
      mEdges = n;
      @(negedge clk);
      checkPins(tag);
   endtask

   task automatic runIdle(input int cycles, input logic lz, input string tag);
      for (int i = 0; i < cycles; i++) applyStimulus(1'b0, value, lz, tag);
   endtask

   // Step until the counter/index after the latest edge match the target.
   task automatic runUntil(input int cnt, input int idx, input logic lz, input string tag);
      int guard;
      guard = 0;
      while (!((mEdges % SD) == cnt && ((mEdges / SD) % D) == idx) && guard < 200) begin
         applyStimulus(1'b0, value, lz, tag);
         guard++;
      end
      checkOutput({tag, ".reach"}, 16'(guard < 200), 16'h0001);
   endtask

   initial begin
      logic [15:0] rv;
      logic        rl;
      logic        rz;

      reset   = 1'b1;
      load    = 1'b0;
      value   = 16'h0000;
      lzBlank = 1'b0;
      modelReset();

      // Reset state, with a load during reset that must be ignored.
      @(negedge clk);
      load  = 1'b1;
      value = 16'hFFFF;
      @(negedge clk);
      checkPins("reset");
      load   = 1'b0;
      reset  = 1'b0;
      #1;
      checkPins("release");

      // First pass: the ignored load means digit 1 must read 0.
      runIdle(2 * SD, 1'b0, "noload");

      // Basic scan of 16'h1A3F over two full passes.
      runUntil(0, 0, 1'b0, "align0");
      applyStimulus(1'b1, 16'h1A3F, 1'b0, "load1A3F");
      runIdle(2 * D * SD, 1'b0, "scan1A3F");

      // Leading-zero blanking, then an all-zero word.
      applyStimulus(1'b1, 16'h0040, 1'b1, "load0040");
      runIdle(2 * D * SD, 1'b1, "lz0040");
      applyStimulus(1'b1, 16'h0000, 1'b1, "load0000");
      runIdle(2 * D * SD, 1'b1, "lz0000");

      // Load on the clock that lights digit 1: digit 1 keeps the old word.
      applyStimulus(1'b1, 16'h1234, 1'b0, "load1234");
      runUntil(DD - 1, 1, 1'b0, "alignLit1");
      applyStimulus(1'b1, 16'h5678, 1'b0, "loadAtLit");
      runIdle(D * SD, 1'b0, "afterLit");

      // Load on the slot wrap edge: applies one slot later.
      runUntil(SD - 1, 2, 1'b0, "alignWrap");
      applyStimulus(1'b1, 16'h9ABC, 1'b0, "loadAtWrap");
      runIdle(D * SD, 1'b0, "afterWrap");

      // Asynchronous reset at slot count 5 of digit 2.
      runUntil(5, 2, 1'b0, "alignRst");
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkPins("asyncRst");
      @(negedge clk);
      reset = 1'b0;
      runUntil(DD + 1, 0, 1'b0, "firstLit");

      // Walk every nibble through digit 0.
      for (int nib = 0; nib < 16; nib++) begin
         applyStimulus(1'b1, 16'(nib), 1'b0, "walkLoad");
         runIdle(D * SD + SD, 1'b0, "walk");
      end

      // Randomised loads, words with varied leading zeros, live lz_blank.
      for (int i = 0; i < 1500; i++) begin
         rv = 16'($urandom) >> ($urandom_range(0, 4) * 4);
         rl = ($urandom_range(0, 11) == 0);
         rz = ($urandom_range(0, 63) == 0) ? ~lzBlank : lzBlank;
         applyStimulus(rl, rv, rz, "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Time-multiplexed driver for a common-anode bank of DIGITS seven-segment displays.
- Captures a hex word on a load strobe and scans one digit per SCAN_DIV clocks.
- Inserts a dead (all-off) interval between digits to prevent ghosting; optionally blanks leading zeros.
- Sits between the CPU debug/status register and the board display pins; replaces a static one-decoder-per-digit arrangement.

Parameters:
- DIGITS, 8, number of hex digits (1..16); value width is 4*DIGITS.
- SCAN_DIV, 1000, clocks each digit is driven, including the dead interval (>= DEAD+2).
- DEAD, 4, clocks at the start of each digit slot with all anodes off.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  hex word; digit i = value[4i+3:4i], digit 0 = least significant, rightmost.
- load  in  1  single-cycle strobe; captures value into the shadow register.
- lz_blank  in  1  1 = blank leading zero digits; sampled live.
- anodes  out  DIGITS  active-low one-hot digit enable.
- segments  out  7  active-low segment pattern; bit0 = a (top) … bit5 = f, bit6 = g (middle).
- busy  out  1  high while a scan pass is in progress; low only in the first slot of digit 0 after reset.

Behaviour:
- Reset, asynchronous:
  - shadow register = 0, digit index = 0, slot counter = 0.
  - anodes = all 1, segments = 7'h7F, busy = 0.
- Shadow register:
  - On load=1, shadow <= value at that clock edge.
  - The new value is visible from the next digit slot onward. The digit currently lit is never changed mid-slot.
  - load during reset is ignored.
- Slot counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0 and advances the digit index.
  - Digit index wraps DIGITS-1 -> 0.
  - busy rises on the first wrap and stays 1 until reset.
- Within a slot:
  - Slot counter < DEAD: anodes = all 1, segments = 7'h7F.
  - Otherwise: anodes bit[index] = 0, all other bits = 1; segments = encode(shadow digit[index]).
  - Outputs are registered: one clock latency from counter/index to pins.
- Encoding, active-low:
  - 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=18 A=08 b=03 C=46 d=21 E=06 F=0E (hex of segments[6:0]).
- Leading-zero blanking (lz_blank=1):
  - Digit i is blanked (segments 7'h7F, anode still asserted) if shadow digits DIGITS-1..i are all zero and i != 0.
  - Digit 0 always shows, so a zero word displays "0".
  - Computed combinationally from shadow; registered with the outputs.
- Simultaneous load and slot wrap: the new digit slot uses the old shadow value; the new value applies from the following slot.
- Reset mid-slot: outputs go dark immediately (asynchronous); scan restarts at digit 0, slot count 0.

Optional Feature:
- Macro: SEG_SCAN_BLINK_EN.
- Defined:
  - Adds input blink_mask[DIGITS] and a free-running 24-bit blink counter, reset to 0.
  - While blink counter bit[23] = 1, digits whose mask bit is 1 are driven blank (segments 7'h7F).
  - Blink counter is unaffected by load.
- Undefined: no port, no counter; behaviour exactly as above.

Decomposition:
- Package seg_pkg:
  - typedef logic [6:0] seg_t.
  - constant SEG_BLANK = 7'h7F.
  - 16-entry encode table constant SEG_HEX_LUT.
  - function seg_encode(logic [3:0]).
- Sub-module seg_lz_mask: purely combinational, shadow -> DIGITS-bit blank mask. Natural and separately testable.
- Scan FSM, counters and output registers stay in seg_scan_driver.

Test Plan:
- Reset release, DIGITS=4, SCAN_DIV=8, DEAD=2, load value 16'h1A3F -> per slot, 2 dark clocks then:
  - anodes 1110 with segments 0E;
  - then 1101 / 30;
  - then 1011 / 08;
  - then 0111 / 79;
  - then wrap to digit 0.
- lz_blank=1, load 16'h0040 -> digits 3 and 2 show 7F with anode low; digit 1 shows 19; digit 0 shows 40. Load 0 -> only digit 0 shows 40.
- load asserted on the clock where digit 1 becomes lit -> digit 1 keeps the old value for that whole slot; new value appears from digit 2's slot.
- Assert reset at slot count 5 of digit 2 -> anodes = F and segments = 7F in the same cycle; after release the first lit digit is digit 0, at count DEAD+1.
- Walk all 16 nibble values through digit 0 -> segments match the encode table exactly.
- SEG_SCAN_BLINK_EN defined, blink_mask = 4'b0010 -> digit 1 dark while the blink counter bit is high; other digits unaffected.
